// File: rtl/vga_pattern_gen.sv
// 640x480@60 VGA timing generator with four test patterns, packed for a TinyVGA PMOD.
// Optional horizontal scroll (1 px per frame) is enabled by defining PATTERN_SCROLL_EN.
module vga_pattern_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic [7:0] vga_out,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       active,
    output logic       frame_start
);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS_C   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS_C   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [7:0] VGA_RST_C = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

    // Returns {R[1:0],G[1:0],B[1:0]} for the selected pattern at column x, line y.
    function automatic logic [5:0] pattern_rgb(input logic [1:0] sel,
                                               input logic [8:0] x,
                                               input logic [8:0] y);
        logic [3:0] xy;
        logic [2:0] bar;
        logic [5:0] rgb;
        xy  = x[7:4] ^ y[7:4];
        bar = x[8:6];
        rgb = 6'b000000;
        case (sel)
            2'd0: rgb = {xy[1:0], xy[2:1], xy[3:2]};
            2'd1: rgb = (x[5] ^ y[5]) ? 6'b111111 : 6'b000000;
            2'd2: begin
                if (bar == 3'b000) begin
                    bar = 3'b111;
                end else begin
                    bar = x[8:6];
                end
                rgb = {{2{bar[2]}}, {2{bar[1]}}, {2{bar[0]}}};
            end
            2'd3: rgb = {x[8:7], y[8:7], x[8:7] ^ y[8:7]};
            default: rgb = 6'b000000;
        endcase
        return rgb;
    endfunction

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [1:0] pat_q, pat_d;
    logic [7:0] vga_q, vga_d;
    logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
    logic       act_q, act_d, fs_q, fs_d;

    logic       origin_s, vis_s, hs_s, vs_s;
    logic [1:0] pat_use_s;
    logic [8:0] x_s;
    logic [5:0] rgb_s;

`ifdef PATTERN_SCROLL_EN
    logic [7:0] frm_q, frm_d;
    assign x_s = h_q[8:0] + {1'b0, frm_q};
`else
    assign x_s = h_q[8:0];
`endif

    // The frame's pattern is taken at pixel (0,0) so that pixel already shows it.
    assign origin_s  = (h_q == 10'd0) && (v_q == 10'd0);
    assign pat_use_s = origin_s ? pattern_sel : pat_q;
    assign vis_s     = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hs_s      = ((h_q >= H_SS_C) && (h_q <= H_SE_C)) ? SYNC_POL : ~SYNC_POL;
    assign vs_s      = ((v_q >= V_SS_C) && (v_q <= V_SE_C)) ? SYNC_POL : ~SYNC_POL;
    assign rgb_s     = vis_s ? pattern_rgb(pat_use_s, x_s, v_q[8:0]) : 6'b000000;

    // Next-state: counters advance and outputs load only on en cycles.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        pat_d  = pat_q;
        vga_d  = vga_q;
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        act_d  = act_q;
        fs_d   = fs_q;
`ifdef PATTERN_SCROLL_EN
        frm_d  = frm_q;
`endif
        if (en) begin
            pat_d  = pat_use_s;
            vga_d  = {hs_s, rgb_s[0], rgb_s[2], rgb_s[4], vs_s, rgb_s[1], rgb_s[3], rgb_s[5]};
            hpos_d = h_q;
            vpos_d = v_q;
            act_d  = vis_s;
            fs_d   = origin_s;
            if (h_q == H_LAST_C) begin
                h_d = 10'd0;
                if (v_q == V_LAST_C) begin
                    v_d = 10'd0;
`ifdef PATTERN_SCROLL_EN
                    frm_d = frm_q + 8'd1;
`endif
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end else begin
            h_d = h_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= 10'd0;
            v_q    <= 10'd0;
            pat_q  <= 2'd0;
            vga_q  <= VGA_RST_C;
            hpos_q <= 10'd0;
            vpos_q <= 10'd0;
            act_q  <= 1'b0;
            fs_q   <= 1'b0;
`ifdef PATTERN_SCROLL_EN
            frm_q  <= 8'd0;
`endif
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            pat_q  <= pat_d;
            vga_q  <= vga_d;
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            act_q  <= act_d;
            fs_q   <= fs_d;
`ifdef PATTERN_SCROLL_EN
            frm_q  <= frm_d;
`endif
        end
    end

    assign vga_out     = vga_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign active      = act_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a full-size instance plus a reduced-timing instance, both
// checked against a pixel-index model (pixel n of the run -> column, line, frame).
module tb_vga_pattern_gen;
    typedef struct packed {
        logic [7:0] vga;
        logic [9:0] h;
        logic [9:0] v;
        logic       act;
        logic       fs;
    } obs_t;

    localparam int FT_F = 800 * 525;
    localparam int FT_S = 200 * 32;
    localparam obs_t RST_OBS = '{vga: 8'h88, h: 10'd0, v: 10'd0, act: 1'b0, fs: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic [7:0] vga_f, vga_s;
    logic [9:0] hpos_f, vpos_f, hpos_s, vpos_s;
    logic active_f, fs_f, active_s, fs_s;
    obs_t obs_f, obs_s, exp_f, exp_s;
    int n = 0;
    logic [1:0] pat_f = 2'd0, pat_s = 2'd0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vga_pattern_gen dut_full (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .vga_out(vga_f), .hpos(hpos_f), .vpos(vpos_f), .active(active_f), .frame_start(fs_f)
    );

    vga_pattern_gen #(
        .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(16),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0)
    ) dut_small (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .vga_out(vga_s), .hpos(hpos_s), .vpos(vpos_s), .active(active_s), .frame_start(fs_s)
    );

    assign obs_f = {vga_f, hpos_f, vpos_f, active_f, fs_f};
    assign obs_s = {vga_s, hpos_s, vpos_s, active_s, fs_s};

    // Expected registered output for the n-th advanced pixel since reset.
    function automatic obs_t model_pixel(int ht, int ha, int hfp, int hsw, int vt, int va,
                                         int vfp, int vsw, int idx, logic [1:0] pat);
        int ft, p, h, v, x, xy, bar;
        logic [1:0] r, g, b;
        logic vis, hs, vs;
        obs_t o;
        ft = ht * vt;
        p  = idx % ft;
        h  = p % ht;
        v  = p / ht;
`ifdef PATTERN_SCROLL_EN
        x = (h + (idx / ft) % 256) % 1024;
`else
        x = h;
`endif
        case (pat)
            2'd0: begin
                xy = x ^ v;
                r = 2'(xy >> 4); g = 2'(xy >> 5); b = 2'(xy >> 6);
            end
            2'd1: begin
                r = ((((x >> 5) ^ (v >> 5)) & 1) != 0) ? 2'b11 : 2'b00;
                g = r; b = r;
            end
            2'd2: begin
                bar = (x >> 6) & 7;
                if (bar == 0) bar = 7;
                r = ((bar & 4) != 0) ? 2'b11 : 2'b00;
                g = ((bar & 2) != 0) ? 2'b11 : 2'b00;
                b = ((bar & 1) != 0) ? 2'b11 : 2'b00;
            end
            default: begin
                r = 2'(x >> 7); g = 2'(v >> 7); b = r ^ g;
            end
        endcase
        vis = (h < ha) && (v < va);
        if (!vis) begin r = 2'b00; g = 2'b00; b = 2'b00; end
        hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
        vs = !((v >= va + vfp) && (v < va + vfp + vsw));
        o.vga = {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
        o.h = 10'(h); o.v = 10'(v); o.act = vis; o.fs = (p == 0);
        return o;
    endfunction

    function automatic obs_t model_small(int idx, logic [1:0] pat);
        return model_pixel(200, 160, 8, 16, 32, 24, 2, 2, idx, pat);
    endfunction

    // Drive one clock with the given en, advancing the model alongside.
    task automatic tick(input logic en_v);
        en = en_v;
        if (rst) begin
            n = 0; pat_f = 2'd0; pat_s = 2'd0; exp_f = RST_OBS; exp_s = RST_OBS;
        end else if (en_v) begin
            if (n % FT_F == 0) pat_f = pattern_sel;
            if (n % FT_S == 0) pat_s = pattern_sel;
            exp_f = model_pixel(800, 640, 16, 96, 525, 480, 10, 2, n, pat_f);
            exp_s = model_small(n, pat_s);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pattern_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            checks += 2;
            if (obs_f !== RST_OBS) begin errors++; $display("FAIL reset_full got %h want %h", obs_f, RST_OBS); end
            if (obs_s !== RST_OBS) begin errors++; $display("FAIL reset_small got %h want %h", obs_s, RST_OBS); end
        end
        rst = 1'b0;
        tick(1'b1);
        checks += 3;
        if (obs_f !== exp_f) begin errors++; $display("FAIL first_pixel_full got %h want %h", obs_f, exp_f); end
        if (obs_s !== exp_s) begin errors++; $display("FAIL first_pixel_small got %h want %h", obs_s, exp_s); end
        if ({fs_f, hpos_f, vpos_f, active_f, vga_f} !== {1'b1, 10'd0, 10'd0, 1'b1, 8'h88}) begin
            errors++; $display("FAIL origin_pixel got fs=%b h=%0d v=%0d act=%b vga=%h", fs_f, hpos_f, vpos_f, active_f, vga_f);
        end
    endtask

    task automatic test_line;
        int hs_low, first_low, inact;
        hs_low = 0; first_low = -1; inact = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1'b1);
            checks += 2;
            if (obs_f !== exp_f) begin errors++; $display("FAIL line_full got %h want %h", obs_f, exp_f); end
            if (obs_s !== exp_s) begin errors++; $display("FAIL line_small got %h want %h", obs_s, exp_s); end
            if (!vga_f[7]) begin
                hs_low++;
                if (first_low < 0) first_low = int'(hpos_f);
            end
            if (!active_f) inact++;
            if (hpos_f == 10'd32 && vpos_f == 10'd0) begin
                checks++;
                if (vga_f !== 8'hFF) begin errors++; $display("FAIL checker_32_0 got %h want ff", vga_f); end
            end
        end
        checks += 4;
        if (hs_low != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", hs_low); end
        if (first_low != 656) begin errors++; $display("FAIL hsync_start got %0d want 656", first_low); end
        if (inact != 160) begin errors++; $display("FAIL blank_width got %0d want 160", inact); end
        if (hpos_f !== 10'd0 || vpos_f !== 10'd1) begin
            errors++; $display("FAIL line_period got h=%0d v=%0d want h=0 v=1", hpos_f, vpos_f);
        end
    endtask

    task automatic test_enable_hold;
        logic seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        obs_t prev_f, prev_s;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                prev_f = obs_f; prev_s = obs_s;
                tick(seq[i]);
                checks += 2;
                if (seq[i]) begin
                    if (hpos_f !== prev_f.h + 10'd1) begin errors++; $display("FAIL en_advance got %0d want %0d", hpos_f, prev_f.h + 10'd1); end
                    if (obs_s !== exp_s) begin errors++; $display("FAIL en_small got %h want %h", obs_s, exp_s); end
                end else begin
                    if (obs_f !== prev_f) begin errors++; $display("FAIL en_hold_full got %h want %h", obs_f, prev_f); end
                    if (obs_s !== prev_s) begin errors++; $display("FAIL en_hold_small got %h want %h", obs_s, prev_s); end
                end
            end
        end
    endtask

    task automatic test_random_run;
        int en_cycles, since, vs_low, seen;
        logic e;
        en_cycles = 0; since = 0; vs_low = 0; seen = 0;
        for (int cyc = 0; cyc < 40000 && en_cycles < 20500; cyc++) begin
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) pattern_sel = 2'($urandom);
            tick(e);
            checks += 2;
            if (obs_f !== exp_f) begin errors++; $display("FAIL rand_full got %h want %h", obs_f, exp_f); end
            if (obs_s !== exp_s) begin errors++; $display("FAIL rand_small got %h want %h", obs_s, exp_s); end
            if (e) begin
                en_cycles++;
                if (fs_s) begin
                    if (seen != 0) begin
                        checks += 2;
                        if (since != FT_S) begin errors++; $display("FAIL frame_period got %0d want %0d", since, FT_S); end
                        if (vs_low != 400) begin errors++; $display("FAIL vsync_width got %0d want 400", vs_low); end
                    end
                    seen = 1; since = 0; vs_low = 0;
                end
                since++;
                if (!vga_s[3]) vs_low++;
            end
        end
        checks++;
        if (en_cycles < 20500) begin errors++; $display("FAIL rand_budget got %0d want 20500", en_cycles); end
    endtask

    task automatic test_reset_midframe;
        pattern_sel = 2'd0;
        rst = 1'b1;
        tick(1'b1);
        checks += 2;
        if (obs_f !== RST_OBS) begin errors++; $display("FAIL midrst_full got %h want %h", obs_f, RST_OBS); end
        if (obs_s !== RST_OBS) begin errors++; $display("FAIL midrst_small got %h want %h", obs_s, RST_OBS); end
        rst = 1'b0;
        tick(1'b0);
        checks++;
        if (obs_s !== RST_OBS) begin errors++; $display("FAIL midrst_hold got %h want %h", obs_s, RST_OBS); end
        tick(1'b1);
        checks += 2;
        if (fs_f !== 1'b1 || fs_s !== 1'b1) begin errors++; $display("FAIL midrst_fs got %b%b want 11", fs_f, fs_s); end
        if (obs_s !== exp_s) begin errors++; $display("FAIL midrst_pixel got %h want %h", obs_s, exp_s); end
    endtask

    task automatic test_pattern_switch;
        obs_t ref_o;
        int cyc;
        cyc = 0;
        while (vpos_s != 10'd10 && cyc < 7000) begin tick(1'b1); cyc++; end
        pattern_sel = 2'd2;
        cyc = 0;
        do begin
            tick(1'b1);
            cyc++;
            checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL switch_small got %h want %h", obs_s, exp_s); end
            if (hpos_s == 10'd80 && vpos_s == 10'd10) begin
                ref_o = model_small(n - 1, 2'd0);
                checks++;
                if (vga_s !== ref_o.vga) begin errors++; $display("FAIL switch_old_pattern got %h want %h", vga_s, ref_o.vga); end
            end
        end while (!fs_s && cyc < 7000);
        ref_o = model_small(n - 1, 2'd2);
        checks += 2;
        if (!fs_s) begin errors++; $display("FAIL switch_timeout got fs=%b want 1", fs_s); end
        if (vga_s !== ref_o.vga) begin errors++; $display("FAIL switch_new_pattern got %h want %h", vga_s, ref_o.vga); end
        for (int i = 0; i < 300; i++) begin
            tick(1'b1);
            checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL switch_after got %h want %h", obs_s, exp_s); end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_enable_hold();
        test_random_run();
        test_reset_midframe();
        test_pattern_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
